l2_tlb_refill_ctrl: RTL and testbench

- Sequencing controller for the 4-way, 64-set L2 TLB.
- Accepts one L1-TLB-miss request at a time and drives a single lookup through the L2 lookup datapath (tag/valid/permission compare, external to this block).
- On L2 miss, issues a page-table-walk request, chooses a victim way with per-set tree pseudo-LRU, commands the array refill, and returns the result.
- Sits between the L1 TLB miss port, the L2 TLB arrays, and the PTW.

---
 rtl/l2_tlb_refill_ctrl_pkg.sv | 47 ++++
 rtl/l2_tlb_refill_ctrl_plru4.sv | 31 +++
 rtl/l2_tlb_refill_ctrl.sv | 167 ++++++++++++++++
 tb/tb_l2_tlb_refill_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_tlb_refill_ctrl_pkg.sv
// Shared definitions for the L2 TLB refill controller: state encoding,
// geometry constants and the 4-way tree pseudo-LRU helpers.
package l2_tlb_refill_ctrl_pkg;

  localparam int NSETS = 64;
  localparam int NWAYS = 4;
  localparam int IDXW  = $clog2(NSETS);
  localparam int WAYW  = $clog2(NWAYS);
  localparam int VPNW  = 28;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_PTW_REQ,
    ST_PTW_WAIT,
    ST_REFILL,
    ST_RESP
  } state_t;

  // bit 0 = b0 (half select), bit 1 = b1 (ways 0/1), bit 2 = b2 (ways 2/3)
  typedef logic [2:0] plru_t;

  function automatic logic [WAYW-1:0] plru_victim(plru_t p);
    if (!p[0]) return {1'b0, p[1]};
    return {1'b1, p[2]};
  endfunction

  // Point every bit on the path to 'way' away from it.
  function automatic plru_t plru_touch(plru_t p, logic [WAYW-1:0] way);
    plru_t n;
    n    = p;
    n[0] = ~way[1];
    if (!way[1]) n[1] = ~way[0];
    else         n[2] = ~way[0];
    return n;
  endfunction

  function automatic logic [WAYW-1:0] first_way(logic [NWAYS-1:0] hits);
    logic [WAYW-1:0] w;
    w = '0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (hits[i]) w = WAYW'(i);
    end
    return w;
  endfunction

endpackage

// File: rtl/l2_tlb_refill_ctrl_plru4.sv
// Per-set tree pseudo-LRU state for the 4-way L2 TLB, with a one-cycle
// clear of every set and a combinational victim query.
module tlb_plru4
  import l2_tlb_refill_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            touch,
  input  logic [IDXW-1:0] touch_idx,
  input  logic [WAYW-1:0] touch_way,
  input  logic [IDXW-1:0] query_idx,
  output logic [WAYW-1:0] victim
);

  plru_t bits_reg [NSETS];

  // Held in flops rather than RAM so that a flush can wipe every set at once.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSETS; i++) begin
      if (reset || clear) begin
        bits_reg[i] <= '0;
      end else if (touch && touch_idx == IDXW'(i)) begin
        bits_reg[i] <= plru_touch(bits_reg[i], touch_way);
      end
    end
  end

  assign victim = plru_victim(bits_reg[query_idx]);

endmodule

// File: rtl/l2_tlb_refill_ctrl.sv
// L2 TLB miss sequencer: one lookup per request, page-table walk on miss,
// PLRU victim refill, and a single-cycle response back to the L1 TLB.
module l2_tlb_refill_ctrl
  import l2_tlb_refill_ctrl_pkg::*;
#(
  parameter int PPNW = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [VPNW-1:0] req_vpn,
  input  logic            req_store,
  output logic            lk_valid,
  output logic [VPNW-1:0] lk_vpn,
  output logic            lk_store,
  input  logic [4:0]      lk_hits,
  input  logic            lk_miss,
  output logic            ptw_req_valid,
  input  logic            ptw_req_ready,
  output logic [VPNW-1:0] ptw_req_vpn,
  input  logic            ptw_resp_valid,
  input  logic            ptw_resp_err,
  input  logic [PPNW-1:0] ptw_resp_ppn,
  output logic            rf_we,
  output logic [IDXW-1:0] rf_idx,
  output logic [WAYW-1:0] rf_way,
  output logic [PPNW-1:0] rf_ppn,
  output logic            resp_valid,
  output logic            resp_hit,
  output logic [WAYW-1:0] resp_way,
  output logic            resp_err,
  input  logic            flush
);

  state_t          state;
  logic [VPNW-1:0] vpn_reg;
  logic            store_reg;
  logic [PPNW-1:0] ppn_reg;
  logic            req_ready_reg, lk_valid_reg, ptw_req_valid_reg;
  logic            rf_we_reg, resp_valid_reg, resp_hit_reg, resp_err_reg;
  logic [WAYW-1:0] rf_way_reg, resp_way_reg;

  logic            lookup_hit;
  logic            touch;
  logic [WAYW-1:0] touch_way;
  logic [WAYW-1:0] victim;

  assign lookup_hit = !lk_hits[4] && (|lk_hits[3:0]);
  assign touch      = !flush && ((state == ST_LOOKUP && lookup_hit) || state == ST_REFILL);
  assign touch_way  = (state == ST_REFILL) ? rf_way_reg : first_way(lk_hits[3:0]);

  tlb_plru4 u_plru (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .touch     (touch),
    .touch_idx (vpn_reg[IDXW-1:0]),
    .touch_way (touch_way),
    .query_idx (vpn_reg[IDXW-1:0]),
    .victim    (victim)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      vpn_reg           <= '0;
      store_reg         <= 1'b0;
      ppn_reg           <= '0;
      req_ready_reg     <= 1'b1;
      lk_valid_reg      <= 1'b0;
      ptw_req_valid_reg <= 1'b0;
      rf_we_reg         <= 1'b0;
      rf_way_reg        <= '0;
      resp_valid_reg    <= 1'b0;
      resp_hit_reg      <= 1'b0;
      resp_way_reg      <= '0;
      resp_err_reg      <= 1'b0;
    end else if (flush) begin
      state             <= ST_IDLE;
      req_ready_reg     <= 1'b1;
      lk_valid_reg      <= 1'b0;
      ptw_req_valid_reg <= 1'b0;
      rf_we_reg         <= 1'b0;
      resp_valid_reg    <= 1'b0;
    end else begin
      lk_valid_reg   <= 1'b0;
      rf_we_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            vpn_reg       <= req_vpn;
            store_reg     <= req_store;
            req_ready_reg <= 1'b0;
            lk_valid_reg  <= 1'b1;
            state         <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (lk_miss && !lk_hits[4] && !lookup_hit) begin
            ptw_req_valid_reg <= 1'b1;
            state             <= ST_PTW_REQ;
          end else begin
            // Bypass, way hit, or a permission reject that needs no walk.
            resp_valid_reg <= 1'b1;
            resp_hit_reg   <= lk_hits[4] || lookup_hit;
            resp_way_reg   <= lookup_hit ? first_way(lk_hits[3:0]) : '0;
            resp_err_reg   <= 1'b0;
            state          <= ST_RESP;
          end
        end
        ST_PTW_REQ: begin
          if (ptw_req_ready) begin
            ptw_req_valid_reg <= 1'b0;
            state             <= ST_PTW_WAIT;
          end
        end
        ST_PTW_WAIT: begin
          if (ptw_resp_valid) begin
            if (ptw_resp_err) begin
              resp_valid_reg <= 1'b1;
              resp_hit_reg   <= 1'b0;
              resp_way_reg   <= '0;
              resp_err_reg   <= 1'b1;
              state          <= ST_RESP;
            end else begin
              ppn_reg    <= ptw_resp_ppn;
              rf_way_reg <= victim;
              rf_we_reg  <= 1'b1;
              state      <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          resp_valid_reg <= 1'b1;
          resp_hit_reg   <= 1'b0;
          resp_way_reg   <= rf_way_reg;
          resp_err_reg   <= 1'b0;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          req_ready_reg <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes are masked by flush so an abort is visible in the same cycle.
  assign req_ready     = req_ready_reg;
  assign lk_valid      = lk_valid_reg && !flush;
  assign lk_vpn        = vpn_reg;
  assign lk_store      = store_reg;
  assign ptw_req_valid = ptw_req_valid_reg && !flush;
  assign ptw_req_vpn   = vpn_reg;
  assign rf_we         = rf_we_reg && !flush;
  assign rf_idx        = vpn_reg[IDXW-1:0];
  assign rf_way        = rf_way_reg;
  assign rf_ppn        = ppn_reg;
  assign resp_valid    = resp_valid_reg && !flush;
  assign resp_hit      = resp_hit_reg;
  assign resp_way      = resp_way_reg;
  assign resp_err      = resp_err_reg;

endmodule

// File: tb/tb_l2_tlb_refill_ctrl.sv
// Randomised self-checking bench for l2_tlb_refill_ctrl with a behavioural
// tree-PLRU / outcome reference model.
module tb_l2_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [27:0] req_vpn = '0;
  logic        req_store = 1'b0;
  logic        lk_valid;
  logic [27:0] lk_vpn;
  logic        lk_store;
  logic [4:0]  lk_hits = '0;
  logic        lk_miss = 1'b0;
  logic        ptw_req_valid;
  logic        ptw_req_ready = 1'b0;
  logic [27:0] ptw_req_vpn;
  logic        ptw_resp_valid = 1'b0;
  logic        ptw_resp_err = 1'b0;
  logic [19:0] ptw_resp_ppn = '0;
  logic        rf_we;
  logic [5:0]  rf_idx;
  logic [1:0]  rf_way;
  logic [19:0] rf_ppn;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        resp_err;
  logic        flush = 1'b0;

  always #5 clk = ~clk;

  l2_tlb_refill_ctrl #(.PPNW(20)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn), .req_store(req_store),
    .lk_valid(lk_valid), .lk_vpn(lk_vpn), .lk_store(lk_store), .lk_hits(lk_hits), .lk_miss(lk_miss),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_resp_valid(ptw_resp_valid), .ptw_resp_err(ptw_resp_err), .ptw_resp_ppn(ptw_resp_ppn),
    .rf_we(rf_we), .rf_idx(rf_idx), .rf_way(rf_way), .rf_ppn(rf_ppn),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_err(resp_err),
    .flush(flush)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference PLRU: per set {b0, b1, b2} as plain bits.
  bit m_b0 [64];
  bit m_b1 [64];
  bit m_b2 [64];

  function automatic int m_victim(int s);
    if (m_b0[s]) return 2 + int'(m_b2[s]);
    return int'(m_b1[s]);
  endfunction

  function automatic void m_touch(int s, int w);
    m_b0[s] = (w < 2);
    if (w < 2) m_b1[s] = (w == 0);
    else       m_b2[s] = (w == 2);
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) begin
      m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0;
    end
  endfunction

  // Expected outcome of one request.
  bit e_hit, e_err, e_rf;
  int e_way, e_lat, e_ptw;

  task automatic model_expect(input logic [27:0] vpn, input logic [4:0] hits, input logic miss,
                              input logic err, input int delay);
    int s;
    s = int'(vpn[5:0]);
    e_hit = 0; e_err = 0; e_rf = 0; e_way = 0; e_lat = 2; e_ptw = 0;
    if (hits[4]) begin
      e_hit = 1;
    end else if (hits[3:0] != 4'b0) begin
      e_hit = 1;
      while (!hits[e_way]) e_way++;
      m_touch(s, e_way);
    end else if (miss) begin
      e_ptw = delay + 1;
      if (err) begin
        e_err = 1;
        e_lat = delay + 5;
      end else begin
        e_rf  = 1;
        e_way = m_victim(s);
        e_lat = delay + 6;
        m_touch(s, e_way);
      end
    end
  endtask

  // Observations from the last request.
  bit          o_done, o_unstable;
  int          o_lat, o_lk, o_ptw, o_rf;
  logic        o_hit, o_err;
  logic [1:0]  o_way, o_rf_way;
  logic [5:0]  o_rf_idx;
  logic [19:0] o_rf_ppn;

  task automatic run_req(input logic [27:0] vpn, input logic store, input logic [4:0] hits,
                         input logic miss, input int delay, input logic err, input logic [19:0] ppn);
    int cyc;
    int gap;
    bit hs;
    cyc = 0; gap = 0; hs = 0;
    o_done = 0; o_unstable = 0; o_lat = 0; o_lk = 0; o_ptw = 0; o_rf = 0;
    o_hit = 0; o_err = 0; o_way = 0; o_rf_way = 0; o_rf_idx = 0; o_rf_ppn = 0;
    @(negedge clk);
    while (!req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b1; req_vpn = vpn; req_store = store; lk_hits = hits; lk_miss = miss;
    @(posedge clk);
    cyc = 0;
    while (!o_done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      ptw_resp_valid = 1'b0;
      if (lk_valid) begin
        o_lk++;
        if (lk_vpn !== vpn || lk_store !== store) o_unstable = 1;
      end
      if (rf_we) begin
        o_rf++; o_rf_idx = rf_idx; o_rf_way = rf_way; o_rf_ppn = rf_ppn;
      end
      if (resp_valid) begin
        o_done = 1; o_lat = cyc; o_hit = resp_hit; o_way = resp_way; o_err = resp_err;
      end
      if (ptw_req_valid) begin
        o_ptw++;
        if (ptw_req_vpn !== vpn) o_unstable = 1;
        ptw_req_ready = (o_ptw > delay);
        hs = hs | ptw_req_ready;
      end else begin
        ptw_req_ready = 1'b0;
        if (hs) begin
          gap++;
          if (gap == 2) begin
            ptw_resp_valid = 1'b1; ptw_resp_err = err; ptw_resp_ppn = ppn;
          end
        end
      end
    end
    ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; lk_hits = '0; lk_miss = 1'b0;
    $display("req vpn=%07h hits=%05b miss=%0d d=%0d err=%0d -> done=%0d lat=%0d hit=%0d way=%0d err=%0d rf=%0d rf_way=%0d",
             vpn, hits, miss, delay, err, o_done, o_lat, o_hit, o_way, o_err, o_rf, o_rf_way);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    n_checks++;
    if ({lk_valid, ptw_req_valid, rf_we, resp_valid, resp_hit, resp_err, resp_way, rf_way, rf_idx,
         rf_ppn, lk_vpn, lk_store, ptw_req_vpn} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero (lk_valid=%b ptw=%b rf_we=%b resp=%b)",
                         lk_valid, ptw_req_valid, rf_we, resp_valid);
    end
  endtask

  task automatic test_hit();
    run_req(28'h0000041, 1'b0, 5'b00100, 1'b0, 0, 1'b0, 20'h0);
    model_expect(28'h0000041, 5'b00100, 1'b0, 1'b0, 0);
    n_checks++;
    if (!o_done || o_lat != 2) begin
      n_fail++; $display("FAIL hit_latency: got done=%0d lat=%0d want lat 2", o_done, o_lat);
    end
    n_checks++;
    if ({o_hit, o_way, o_err} !== {e_hit, 2'(e_way), e_err}) begin
      n_fail++; $display("FAIL hit_resp: got hit=%b way=%0d err=%b want hit=1 way=2 err=0", o_hit, o_way, o_err);
    end
    n_checks++;
    if (o_lk != 1 || o_ptw != 0 || o_rf != 0) begin
      n_fail++; $display("FAIL hit_traffic: got lk=%0d ptw=%0d rf=%0d want 1 0 0", o_lk, o_ptw, o_rf);
    end
  endtask

  task automatic test_miss_refill();
    run_req(28'h0000041, 1'b1, 5'b00000, 1'b1, 3, 1'b0, 20'hABCDE);
    model_expect(28'h0000041, 5'b00000, 1'b1, 1'b0, 3);
    n_checks++;
    if (o_rf != 1 || {o_rf_idx, o_rf_way, o_rf_ppn} !== {6'h01, 2'(e_way), 20'hABCDE}) begin
      n_fail++; $display("FAIL miss_refill: got n=%0d idx=%h way=%0d ppn=%h want 1 01 %0d abcde",
                         o_rf, o_rf_idx, o_rf_way, o_rf_ppn, e_way);
    end
    n_checks++;
    if (!o_done || o_lat != e_lat || {o_hit, o_way, o_err} !== {1'b0, 2'(e_way), 1'b0}) begin
      n_fail++; $display("FAIL miss_resp: got lat=%0d hit=%b way=%0d err=%b want lat=%0d 0 %0d 0",
                         o_lat, o_hit, o_way, o_err, e_lat, e_way);
    end
    n_checks++;
    if (o_unstable || o_ptw != e_ptw) begin
      n_fail++; $display("FAIL miss_ptw_hold: got unstable=%0d ptw_cycles=%0d want 0 %0d", o_unstable, o_ptw, e_ptw);
    end
  endtask

  task automatic test_plru_sequence();
    int exp_seq [5];
    logic [27:0] vpn;
    exp_seq = '{0, 2, 1, 3, 0};
    test_reset();
    for (int i = 0; i < 5; i++) begin
      vpn = 28'($urandom);
      vpn[5:0] = 6'd5;
      run_req(vpn, 1'b0, 5'b0, 1'b1, i % 3, 1'b0, 20'($urandom));
      model_expect(vpn, 5'b0, 1'b1, 1'b0, i % 3);
      n_checks++;
      if (o_rf != 1 || o_rf_way !== 2'(exp_seq[i]) || o_way !== 2'(exp_seq[i])) begin
        n_fail++; $display("FAIL plru_seq[%0d]: got rf=%0d victim=%0d resp_way=%0d want victim %0d",
                           i, o_rf, o_rf_way, o_way, exp_seq[i]);
      end
    end
  endtask

  task automatic test_ptw_error();
    run_req(28'h0000009, 1'b0, 5'b0, 1'b1, 1, 1'b0, 20'h11111);
    model_expect(28'h0000009, 5'b0, 1'b1, 1'b0, 1);
    run_req(28'h0000049, 1'b0, 5'b0, 1'b1, 2, 1'b1, 20'h22222);
    model_expect(28'h0000049, 5'b0, 1'b1, 1'b1, 2);
    n_checks++;
    if (o_rf != 0 || !o_done || o_lat != e_lat || {o_hit, o_err} !== 2'b01) begin
      n_fail++; $display("FAIL ptw_err: got rf=%0d lat=%0d hit=%b err=%b want 0 %0d 0 1", o_rf, o_lat, o_hit, o_err, e_lat);
    end
    run_req(28'h0000089, 1'b0, 5'b0, 1'b1, 0, 1'b0, 20'h33333);
    model_expect(28'h0000089, 5'b0, 1'b1, 1'b0, 0);
    n_checks++;
    if (o_rf != 1 || o_rf_way !== 2'(e_way)) begin
      n_fail++; $display("FAIL ptw_err_plru: got rf=%0d victim=%0d want 1 %0d", o_rf, o_rf_way, e_way);
    end
  endtask

  task automatic test_bypass();
    run_req(28'h0000009, 1'b1, 5'b10110, 1'b1, 0, 1'b0, 20'h0);
    model_expect(28'h0000009, 5'b10110, 1'b1, 1'b0, 0);
    n_checks++;
    if (!o_done || o_lat != 2 || {o_hit, o_way, o_err} !== 4'b1000 || o_ptw != 0 || o_rf != 0) begin
      n_fail++; $display("FAIL bypass: got lat=%0d hit=%b way=%0d err=%b ptw=%0d rf=%0d want 2 1 0 0 0 0",
                         o_lat, o_hit, o_way, o_err, o_ptw, o_rf);
    end
    run_req(28'h0000003, 1'b1, 5'b00000, 1'b0, 0, 1'b0, 20'h0);
    model_expect(28'h0000003, 5'b00000, 1'b0, 1'b0, 0);
    n_checks++;
    if (!o_done || o_lat != 2 || {o_hit, o_err} !== 2'b00 || o_ptw != 0 || o_rf != 0) begin
      n_fail++; $display("FAIL reject: got lat=%0d hit=%b err=%b ptw=%0d rf=%0d want 2 0 0 0 0",
                         o_lat, o_hit, o_err, o_ptw, o_rf);
    end
  endtask

  task automatic test_flush();
    int cyc;
    int bad;
    bit seen;
    int sets [3];
    logic [27:0] vpn;
    cyc = 0; bad = 0; seen = 0;
    sets = '{1, 5, 9};
    @(negedge clk);
    req_valid = 1'b1; req_vpn = 28'h0000105; lk_miss = 1'b1; lk_hits = '0;
    @(posedge clk);
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      seen = ptw_req_valid;
    end
    ptw_req_ready = 1'b1;
    @(negedge clk);
    ptw_req_ready = 1'b0;
    lk_miss = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (!seen || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready: got ptw_seen=%0d req_ready=%b want 1 1", seen, req_ready);
    end
    ptw_resp_valid = 1'b1; ptw_resp_err = 1'b0; ptw_resp_ppn = 20'h55555;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ptw_resp_valid = 1'b0;
      if (rf_we || resp_valid || ptw_req_valid) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL flush_late_resp: got %0d cycles with activity want 0", bad);
    end
    m_clear();
    for (int i = 0; i < 3; i++) begin
      vpn = {22'($urandom), 6'(sets[i])};
      run_req(vpn, 1'b0, 5'b0, 1'b1, 0, 1'b0, 20'($urandom));
      model_expect(vpn, 5'b0, 1'b1, 1'b0, 0);
      n_checks++;
      if (o_rf != 1 || o_rf_way !== 2'(e_way) || o_rf_way !== 2'd0) begin
        n_fail++; $display("FAIL flush_plru_set%0d: got rf=%0d victim=%0d want 1 0", sets[i], o_rf, o_rf_way);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] vpn;
    logic [4:0]  hits;
    logic        miss, err;
    logic [19:0] ppn;
    int          kind, delay;
    for (int i = 0; i < 40; i++) begin
      vpn = 28'($urandom);
      vpn[5:0] = 6'($urandom_range(0, 3));
      kind = $urandom_range(0, 9);
      hits = '0; miss = 1'b0; err = 1'b0;
      if (kind == 0)      hits = 5'b10000 | 5'($urandom_range(0, 15));
      else if (kind <= 3) hits = 5'($urandom_range(1, 15));
      else if (kind <= 8) begin
        miss = 1'b1;
        err  = ($urandom_range(0, 4) == 0);
      end
      delay = $urandom_range(0, 3);
      ppn   = 20'($urandom);
      run_req(vpn, 1'($urandom), hits, miss, delay, err, ppn);
      model_expect(vpn, hits, miss, err, delay);
      n_checks++;
      if (!o_done || o_lat != e_lat || {o_hit, o_way, o_err} !== {e_hit, 2'(e_way), e_err}) begin
        n_fail++; $display("FAIL rand_resp[%0d]: got done=%0d lat=%0d hit=%b way=%0d err=%b want lat=%0d hit=%0d way=%0d err=%0d",
                           i, o_done, o_lat, o_hit, o_way, o_err, e_lat, e_hit, e_way, e_err);
      end
      n_checks++;
      if (o_rf != int'(e_rf) || o_ptw != e_ptw || o_lk != 1 || o_unstable ||
          (e_rf && {o_rf_idx, o_rf_way, o_rf_ppn} !== {vpn[5:0], 2'(e_way), ppn})) begin
        n_fail++; $display("FAIL rand_side[%0d]: got rf=%0d ptw=%0d lk=%0d unst=%0d idx=%h way=%0d ppn=%h want rf=%0d ptw=%0d way=%0d ppn=%h",
                           i, o_rf, o_ptw, o_lk, o_unstable, o_rf_idx, o_rf_way, o_rf_ppn, e_rf, e_ptw, e_way, ppn);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hit();
    test_miss_refill();
    test_plru_sequence();
    test_ptw_error();
    test_bypass();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
